// File: rtl/sys_bus_responder.sv
// sys_bus_responder: CPU system-bus slave in front of a single-port RAM.
// Latches an address on ALE, runs a read or write with a programmable
// number of wait states, and stalls the CPU through nWait until the
// access has completed. Out-of-range addresses and strobe contention
// are reported on BusErr without touching the RAM.
module sys_bus_responder #(
    parameter int WAIT_STATES = 1,   // extra wait cycles per access, 0..7
    parameter int ADDR_BITS   = 10   // implemented RAM word-address width
) (
    input  logic                 Clock,
    input  logic                 nReset,
    input  logic [15:0]          SysBus,
    input  logic                 ALE,
    input  logic                 nOE,
    input  logic                 nWE,
    output logic [15:0]          DataIn,
    output logic                 nWait,
    output logic                 BusErr,
    output logic [ADDR_BITS-1:0] RamAddr,
    output logic [15:0]          RamWData,
    input  logic [15:0]          RamRData,
    output logic                 RamRe,
    output logic                 RamWe
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WAIT,
        S_MEM,
        S_CAP,
        S_HOLD
    } state_t;

    localparam logic [2:0] WAIT_LOAD = 3'(WAIT_STATES);

    state_t      state;
    logic [15:0] addr_reg;
    logic [15:0] wdata_reg;
    logic [15:0] data_reg;
    logic [2:0]  wait_cnt;
    logic        is_write;
    logic        out_of_range;
    logic        strobe_released;

    // Any address bit above the implemented RAM range makes the access illegal.
    assign out_of_range    = (addr_reg >> ADDR_BITS) != 16'h0000;
    // The strobe that started the current access has gone inactive.
    assign strobe_released = is_write ? nWE : nOE;

    // RAM address and write data come straight from their holding registers.
    assign RamAddr  = addr_reg[ADDR_BITS-1:0];
    assign RamWData = wdata_reg;

    // Access sequencer: state, holding registers and all registered outputs.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state     <= S_IDLE;
            addr_reg  <= 16'h0000;
            wdata_reg <= 16'h0000;
            data_reg  <= 16'h0000;
            wait_cnt  <= 3'd0;
            is_write  <= 1'b0;
            DataIn    <= 16'h0000;
            nWait     <= 1'b1;
            BusErr    <= 1'b0;
            RamRe     <= 1'b0;
            RamWe     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch reads
            // the pre-edge register values and later defaults cannot race.
            // Strobes and read data default low; branches below override them,
            // which keeps RamRe/RamWe to exactly one cycle.
            RamRe  <= 1'b0;
            RamWe  <= 1'b0;
            DataIn <= 16'h0000;

            case (state)
                S_IDLE, S_ADDR: begin
                    if (ALE) begin
                        addr_reg <= SysBus;
                        BusErr   <= 1'b0;
                        state    <= S_ADDR;
                    end else if (state == S_ADDR && (!nOE || !nWE)) begin
                        nWait    <= 1'b0;
                        data_reg <= 16'h0000;
                        wait_cnt <= WAIT_LOAD;
                        is_write <= !nWE;
                        if (!nWE && nOE) begin
                            wdata_reg <= SysBus;
                        end
                        if (out_of_range || (!nOE && !nWE)) begin
                            // Illegal access: report it and skip the RAM entirely.
                            BusErr <= 1'b1;
                            state  <= S_HOLD;
                        end else if (WAIT_STATES > 0) begin
                            state <= S_WAIT;
                        end else begin
                            state <= S_MEM;
                            RamRe <= nWE;
                            RamWe <= !nWE;
                        end
                    end
                end

                S_WAIT: begin
                    if (strobe_released) begin
                        // CPU gave up before the RAM was touched.
                        state    <= S_IDLE;
                        nWait    <= 1'b1;
                        wait_cnt <= 3'd0;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                        if (wait_cnt == 3'd1) begin
                            state <= S_MEM;
                            RamRe <= !is_write;
                            RamWe <= is_write;
                        end
                    end
                end

                S_MEM: begin
                    if (is_write) begin
                        state <= S_HOLD;
                        nWait <= 1'b1;
                    end else begin
                        state <= S_CAP;
                    end
                end

                S_CAP: begin
                    data_reg <= RamRData;
                    DataIn   <= nOE ? 16'h0000 : RamRData;
                    nWait    <= 1'b1;
                    state    <= S_HOLD;
                end

                S_HOLD: begin
                    nWait <= 1'b1;
                    if (nOE && nWE) begin
                        state <= S_IDLE;
                    end else begin
                        DataIn <= nOE ? 16'h0000 : data_reg;
                    end
                end

                default: begin
                    state <= S_IDLE;
                    nWait <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sys_bus_responder.sv
// Self-checking bench for sys_bus_responder: a timeline-based reference
// model plus a behavioural RAM, directed bus sequences with literal
// expectations, then randomized bus traffic compared every cycle.
module tb_sys_bus_responder;

    localparam int WS = 1;
    localparam int AB = 10;

    logic          Clock;
    logic          nReset;
    logic [15:0]   SysBus;
    logic          ALE;
    logic          nOE;
    logic          nWE;
    logic [15:0]   DataIn;
    logic          nWait;
    logic          BusErr;
    logic [AB-1:0] RamAddr;
    logic [15:0]   RamWData;
    logic [15:0]   RamRData;
    logic          RamRe;
    logic          RamWe;

    sys_bus_responder #(
        .WAIT_STATES (WS),
        .ADDR_BITS   (AB)
    ) dut (
        .Clock    (Clock),
        .nReset   (nReset),
        .SysBus   (SysBus),
        .ALE      (ALE),
        .nOE      (nOE),
        .nWE      (nWE),
        .DataIn   (DataIn),
        .nWait    (nWait),
        .BusErr   (BusErr),
        .RamAddr  (RamAddr),
        .RamWData (RamWData),
        .RamRData (RamRData),
        .RamRe    (RamRe),
        .RamWe    (RamWe)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    int n_checks;
    int n_pass;

    // pulse / stall counters kept by the compare process
    int            re_cnt;
    int            we_cnt;
    int            low_cnt;
    logic [AB-1:0] last_re_addr;
    logic [AB-1:0] last_we_addr;
    logic [15:0]   last_we_data;

    // behavioural RAM
    logic [15:0]   ram [0:(1<<AB)-1];
    logic          re_q;
    logic [AB-1:0] a_q;

    // reference model
    logic [15:0] shadow [0:(1<<AB)-1];
    logic        have_addr;
    logic [15:0] m_addr;
    logic [15:0] m_wdata;
    logic [15:0] m_data;
    logic        m_berr;
    logic        active;
    logic        holding;
    logic        rd;
    int          e;
    logic        exp_nwait;
    logic        exp_re;
    logic        exp_we;
    logic [15:0] exp_din;

    // snapshots for directed sequences
    int          re0;
    int          we0;
    int          low0;
    logic [15:0] din_seen;
    logic        berr_seen;

    function automatic logic [15:0] init_word(input int i);
        return 16'((i * 40503) ^ 23130);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic cyc();
        @(posedge Clock);
        #1;
    endtask

    task automatic snap();
        re0  = re_cnt;
        we0  = we_cnt;
        low0 = low_cnt;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (nWait !== 1'b1 && n < 20) begin
            cyc();
            n++;
        end
        check("access_completes", 32'(nWait), 32'd1);
    endtask

    task automatic bus_read(input logic [15:0] addr);
        cyc(); ALE = 1'b1; SysBus = addr;
        cyc(); ALE = 1'b0; nOE = 1'b0; SysBus = 16'($urandom);
        cyc();
        wait_ready();
        din_seen  = DataIn;
        berr_seen = BusErr;
        cyc(); nOE = 1'b1;
        cyc();
        cyc();
    endtask

    task automatic bus_write(input logic [15:0] addr, input logic [15:0] data);
        cyc(); ALE = 1'b1; SysBus = addr;
        cyc(); ALE = 1'b0; nWE = 1'b0; SysBus = data;
        cyc();
        wait_ready();
        berr_seen = BusErr;
        cyc(); nWE = 1'b1;
        cyc();
        cyc();
    endtask

    task automatic model_reset();
        have_addr = 1'b0;
        m_addr    = 16'h0000;
        m_wdata   = 16'h0000;
        m_data    = 16'h0000;
        m_berr    = 1'b0;
        active    = 1'b0;
        holding   = 1'b0;
        rd        = 1'b0;
        e         = 0;
        exp_nwait = 1'b1;
        exp_re    = 1'b0;
        exp_we    = 1'b0;
        exp_din   = 16'h0000;
    endtask

    // One bus edge of the reference model: an access is a timeline measured
    // in edges since its start edge (strobe at WS, hold at WS+1 / WS+2).
    task automatic model_step();
        exp_re = 1'b0;
        exp_we = 1'b0;
        if (holding) begin
            exp_nwait = 1'b1;
            if (nOE && nWE) begin
                holding   = 1'b0;
                have_addr = 1'b0;
            end
        end else if (active) begin
            e++;
            if (e <= WS && (rd ? nOE : nWE)) begin
                active    = 1'b0;
                have_addr = 1'b0;
                exp_nwait = 1'b1;
            end else if (e == WS) begin
                exp_re = rd;
                exp_we = !rd;
            end else if (e == WS + 1 && !rd) begin
                shadow[m_addr[AB-1:0]] = m_wdata;
                active    = 1'b0;
                holding   = 1'b1;
                exp_nwait = 1'b1;
            end else if (e == WS + 2) begin
                m_data    = shadow[m_addr[AB-1:0]];
                active    = 1'b0;
                holding   = 1'b1;
                exp_nwait = 1'b1;
            end
        end else if (ALE) begin
            m_addr    = SysBus;
            have_addr = 1'b1;
            m_berr    = 1'b0;
        end else if (have_addr && (!nOE || !nWE)) begin
            m_data    = 16'h0000;
            exp_nwait = 1'b0;
            have_addr = 1'b0;
            if ((!nOE && !nWE) || m_addr >= 16'(1 << AB)) begin
                m_berr  = 1'b1;
                holding = 1'b1;
            end else begin
                active = 1'b1;
                rd     = !nOE;
                e      = 0;
                if (!rd) m_wdata = SysBus;
                if (WS == 0) begin
                    exp_re = rd;
                    exp_we = !rd;
                end
            end
        end
        exp_din = (holding && !nOE) ? m_data : 16'h0000;
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        n_checks = 0;
        n_pass   = 0;
        re_cnt   = 0;
        we_cnt   = 0;
        low_cnt  = 0;
        last_re_addr = '0;
        last_we_addr = '0;
        last_we_data = '0;
        re_q     = 1'b0;
        a_q      = '0;
        for (int i = 0; i < (1 << AB); i++) begin
            ram[i]    = init_word(i);
            shadow[i] = init_word(i);
        end
        ram[12'h012]    = 16'hBEEF;
        shadow[12'h012] = 16'hBEEF;

        nReset   = 1'b0;
        ALE      = 1'b0;
        nOE      = 1'b1;
        nWE      = 1'b1;
        SysBus   = 16'h0000;
        RamRData = 16'h0000;
        model_reset();
        repeat (2) cyc();

        fork
            // reference model, advanced on every edge and on async reset
            forever begin
                @(posedge Clock or negedge nReset);
                if (!nReset) model_reset();
                else model_step();
            end
            // compare process: DUT outputs against the model every cycle
            forever begin
                @(negedge Clock);
                check("nWait", 32'(nWait), 32'(exp_nwait));
                check("BusErr", 32'(BusErr), 32'(m_berr));
                check("RamRe", 32'(RamRe), 32'(exp_re));
                check("RamWe", 32'(RamWe), 32'(exp_we));
                check("DataIn", 32'(DataIn), 32'(exp_din));
                if (exp_re || exp_we) check("RamAddr", 32'(RamAddr), 32'(m_addr[AB-1:0]));
                if (exp_we) check("RamWData", 32'(RamWData), 32'(m_wdata));
                if (!nReset) begin
                    check("RamAddr_rst", 32'(RamAddr), 32'd0);
                    check("RamWData_rst", 32'(RamWData), 32'd0);
                end
                if (RamRe) begin re_cnt++; last_re_addr = RamAddr; end
                if (RamWe) begin we_cnt++; last_we_addr = RamAddr; last_we_data = RamWData; end
                if (!nWait) low_cnt++;
            end
            // behavioural RAM: write and register read request mid-cycle
            forever begin
                @(negedge Clock);
                re_q = RamRe;
                a_q  = RamAddr;
                if (RamWe) ram[RamAddr] = RamWData;
            end
            // read data valid the cycle after RamRe, garbage otherwise
            forever begin
                @(posedge Clock);
                #1;
                RamRData = re_q ? ram[a_q] : 16'($urandom);
            end
        join_none

        // reset state
        check("rst_nWait", 32'(nWait), 32'd1);
        check("rst_BusErr", 32'(BusErr), 32'd0);
        check("rst_DataIn", 32'(DataIn), 32'd0);
        check("rst_RamRe", 32'(RamRe), 32'd0);
        check("rst_RamWe", 32'(RamWe), 32'd0);
        check("rst_RamAddr", 32'(RamAddr), 32'd0);
        check("rst_RamWData", 32'(RamWData), 32'd0);
        nReset = 1'b1;
        cyc();

        // read sequence
        snap();
        bus_read(16'h0012);
        check("rd_re_pulses", 32'(re_cnt - re0), 32'd1);
        check("rd_ramaddr", 32'(last_re_addr), 32'h012);
        check("rd_wait_low", 32'(low_cnt - low0), 32'd3);
        check("rd_datain", 32'(din_seen), 32'hBEEF);
        check("rd_buserr", 32'(berr_seen), 32'd0);

        // write sequence, then read the word back
        snap();
        bus_write(16'h03FF, 16'h1234);
        check("wr_we_pulses", 32'(we_cnt - we0), 32'd1);
        check("wr_ramaddr", 32'(last_we_addr), 32'h3FF);
        check("wr_wdata", 32'(last_we_data), 32'h1234);
        check("wr_wait_low", 32'(low_cnt - low0), 32'd2);
        bus_read(16'h03FF);
        check("wr_readback", 32'(din_seen), 32'h1234);

        // out-of-range read
        snap();
        bus_read(16'h0400);
        check("oor_re_pulses", 32'(re_cnt - re0), 32'd0);
        check("oor_buserr", 32'(berr_seen), 32'd1);
        check("oor_wait_low", 32'(low_cnt - low0), 32'd1);
        check("oor_datain", 32'(din_seen), 32'h0000);

        // early abort during WAIT, then a normal read
        snap();
        cyc(); ALE = 1'b1; SysBus = 16'h0012;
        cyc(); ALE = 1'b0; nOE = 1'b0;
        cyc(); nOE = 1'b1;
        cyc();
        check("abort_nwait", 32'(nWait), 32'd1);
        cyc();
        check("abort_re_pulses", 32'(re_cnt - re0), 32'd0);
        bus_read(16'h0012);
        check("abort_next_re", 32'(re_cnt - re0), 32'd1);
        check("abort_next_data", 32'(din_seen), 32'hBEEF);
        check("abort_wait_low", 32'(low_cnt - low0), 32'd4);

        // reset during the MEM cycle of a write
        snap();
        cyc(); ALE = 1'b1; SysBus = 16'h0155;
        cyc(); ALE = 1'b0; nWE = 1'b0; SysBus = 16'hABCD;
        cyc();
        cyc();
        check("mem_we_high", 32'(RamWe), 32'd1);
        #1 nReset = 1'b0;
        #1;
        check("midrst_RamWe", 32'(RamWe), 32'd0);
        check("midrst_nWait", 32'(nWait), 32'd1);
        check("midrst_RamRe", 32'(RamRe), 32'd0);
        check("midrst_BusErr", 32'(BusErr), 32'd0);
        check("midrst_DataIn", 32'(DataIn), 32'd0);
        check("midrst_RamAddr", 32'(RamAddr), 32'd0);
        check("midrst_RamWData", 32'(RamWData), 32'd0);
        nWE = 1'b1;
        cyc();
        cyc(); nReset = 1'b1;
        cyc();
        check("midrst_we_pulses", 32'(we_cnt - we0), 32'd0);
        bus_read(16'h0155);
        check("midrst_ram_untouched", 32'(din_seen), 32'(init_word(16'h0155)));

        // strobe contention, BusErr held until the next ALE
        snap();
        cyc(); ALE = 1'b1; SysBus = 16'h0020;
        cyc(); ALE = 1'b0; nOE = 1'b0; nWE = 1'b0;
        cyc();
        check("cont_buserr", 32'(BusErr), 32'd1);
        cyc();
        cyc(); nOE = 1'b1; nWE = 1'b1;
        cyc();
        cyc();
        check("cont_no_strobe", 32'(re_cnt - re0 + we_cnt - we0), 32'd0);
        check("cont_buserr_held", 32'(BusErr), 32'd1);
        cyc(); ALE = 1'b1; SysBus = 16'h0020;
        cyc(); ALE = 1'b0;
        check("cont_ale_clears", 32'(BusErr), 32'd0);

        // randomized traffic checked every cycle by the compare process
        for (int i = 0; i < 3000; i++) begin
            cyc();
            ALE = ($urandom_range(0, 99) < 12);
            if (ALE) SysBus = ($urandom_range(0, 4) == 0) ? 16'($urandom) : 16'($urandom_range(0, 1023));
            else SysBus = 16'($urandom);
            if ($urandom_range(0, 99) < 20) nOE = ~nOE;
            if ($urandom_range(0, 99) < 12) nWE = ~nWE;
            if (!nReset) nReset = 1'b1;
            else if ($urandom_range(0, 999) < 5) nReset = 1'b0;
        end

        cyc(); ALE = 1'b0; nOE = 1'b1; nWE = 1'b1; nReset = 1'b1;
        repeat (5) cyc();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
